imm_gen_pipe: RTL
=================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter TAG_W, default 5, meaning sideband tag width carried alongside each instruction.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  upstream instruction present.
REQ-006 SHALL have port in_ready  output  1  stage accepts an instruction this cycle.
REQ-007 SHALL have port in_op  input  3  immediate format select.
REQ-008 SHALL have port in_inst  input  32  raw instruction word.
REQ-009 SHALL have port in_tag  input  TAG_W  sideband tag, passed through unmodified.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-012 SHALL have port out_imm  output  XLEN  generated immediate.
REQ-013 SHALL have port out_tag  output  TAG_W  tag of the result.
REQ-014 SHALL have port out_illegal  output  1  encoding is not legal for XLEN.

Function
REQ-015 SHALL decode in_op as: 000 zero; 001 I; 010 S; 011 B; 100 U; 101 J; 110 CSR address (inst[31:20] zero-extended); 111 CSR zimm (inst[19:15] zero-extended).
REQ-016 SHALL sign-extend from inst[31] to XLEN for I, S, B, U and J, using the standard RV bit placement, with bit 0 forced to 0 for B and J and bits [11:0] forced to 0 for U.
REQ-017 SHALL, for op I with opcode 0010011 and funct3 001/101, output the zero-extended shamt: inst[25:20] when XLEN=64, inst[24:20] when XLEN=32.
REQ-018 SHALL, for op I with opcode 0011011 and funct3 001/101, output the zero-extended shamt inst[24:20].
REQ-019 SHALL assert out_illegal for: a shift per REQ-017 with XLEN=32 and inst[25]=1; a shift per REQ-018 with inst[25]=1; any opcode 0011011 with XLEN=32. It SHALL be 0 otherwise, and the immediate SHALL still be produced.
REQ-020 SHALL register results: an instruction accepted in cycle N appears on out_* in cycle N+1 (latency 1), at a sustained throughput of 1 per cycle.
REQ-021 SHALL use a 2-entry skid organisation (main register plus skid register), with in_ready = NOT skid_valid, so that in_ready depends only on state.
REQ-022 SHALL hold out_imm, out_tag and out_illegal stable while out_valid=1 and out_ready=0.
REQ-023 SHALL, when the main register is valid and stalled and an input is accepted, capture that input in the skid register; on the next out handshake the skid contents SHALL move to the main register.
REQ-024 SHALL, when an input and an output handshake occur in the same cycle with skid empty, load the main register directly with the new result.
REQ-025 SHALL preserve order and SHALL never drop or duplicate an instruction.
REQ-026 SHALL treat in_op/in_inst/in_tag as don't-care when in_valid=0.

Reset
REQ-027 SHALL, while rstn=0, force out_valid=0, skid_valid=0, in_ready=0, out_imm=0, out_tag=0 and out_illegal=0, independent of clk.
REQ-028 SHALL assert in_ready=1 on the first clock edge after rstn deasserts, and SHALL discard any in-flight entries when reset is asserted mid-operation.

Structure
REQ-029 SHALL take op encodings, opcode constants (0010011, 0011011) and funct3 shift codes from the shared package imm_pkg.
REQ-030 SHALL place the format decode in one combinational sub-module, imm_gen_core (params XLEN; inputs op, inst; outputs imm, illegal), instantiated once before the registers.

Verification
REQ-031 SHALL cover: XLEN=64, op 001, inst 0xFFF00093 -> out_imm 0xFFFFFFFFFFFFFFFF, illegal 0, one cycle later.
REQ-032 SHALL cover: op 001, inst 0x43F0D093 (srai x1,x1,63) -> imm 0x3F at XLEN=64; at XLEN=32 -> imm 0x1F, illegal 1.
REQ-033 SHALL cover: inst 0x300FD073 -> op 110 gives 0x300; op 111 gives 0x1F.
REQ-034 SHALL cover: 4 back-to-back inputs with tags 1..4, with out_ready low for cycles 2-3 -> in_ready drops after 2 accepts and outputs arrive in order 1,2,3,4 with values held while stalled.
REQ-035 SHALL cover: rstn pulled low while both entries are full -> out_valid=0 immediately, no stale result after release.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared encodings for the immediate generator: format selects, opcodes
// and the funct3 values that mark the immediate-shift instructions.
package imm_pkg;

  typedef enum logic [2:0] {
    OP_ZERO = 3'b000,
    OP_I    = 3'b001,
    OP_S    = 3'b010,
    OP_B    = 3'b011,
    OP_U    = 3'b100,
    OP_J    = 3'b101,
    OP_CSR  = 3'b110,
    OP_ZIMM = 3'b111
  } imm_op_e;

  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

  function automatic logic is_shift_f3(input logic [2:0] f3);
    return (f3 == F3_SLL) || (f3 == F3_SRX);
  endfunction

endpackage

// File: rtl/imm_gen_core.sv
// Combinational immediate decode: selects the RV immediate format, handles
// the shift-amount special cases and flags encodings illegal for XLEN.
module imm_gen_core
  import imm_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      op,
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic [6:0] opcode;
  logic       shift_f3;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic signed [31:0] s;
    s = v;
    return XLEN'(s);
  endfunction

  assign opcode   = inst[6:0];
  assign shift_f3 = is_shift_f3(inst[14:12]);

  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (imm_op_e'(op))
      OP_I: begin
        if (opcode == OPC_OP_IMM && shift_f3) begin
          // RV32 has only 5 shamt bits; bit 25 set is a reserved encoding
          if (XLEN == 64) begin
            imm = XLEN'(inst[25:20]);
          end else begin
            imm     = XLEN'(inst[24:20]);
            illegal = inst[25];
          end
        end else if (opcode == OPC_OP_IMM_32 && shift_f3) begin
          imm     = XLEN'(inst[24:20]);
          illegal = inst[25];
        end else begin
          imm = sext32({{20{inst[31]}}, inst[31:20]});
        end
      end
      OP_S:    imm = sext32({{20{inst[31]}}, inst[31:25], inst[11:7]});
      OP_B:    imm = sext32({{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
      OP_U:    imm = sext32({inst[31:12], 12'b0});
      OP_J:    imm = sext32({{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
      OP_CSR:  imm = XLEN'(inst[31:20]);
      OP_ZIMM: imm = XLEN'(inst[19:15]);
      default: imm = '0;
    endcase
    // W-form instructions do not exist on a 32-bit datapath
    if (XLEN == 32 && opcode == OPC_OP_IMM_32) illegal = 1'b1;
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a main/skid register pair so that
// in_ready depends only on state while sustaining one result per cycle.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } ent_t;

  ent_t new_e;
  ent_t main_q, main_d;
  ent_t skid_q, skid_d;
  logic rdy_q, rdy_d;
  logic mv_q, mv_d;
  logic sv_q, sv_d;
  logic acc, deq;

  imm_gen_core #(.XLEN(XLEN)) u_core (
    .op      (in_op),
    .inst    (in_inst),
    .imm     (new_e.imm),
    .illegal (new_e.illegal)
  );
  assign new_e.tag = in_tag;

  // rdy_q keeps in_ready low during reset and raises it on the first edge after
  assign in_ready = rdy_q & ~sv_q;
  assign acc      = in_valid & in_ready;
  assign deq      = mv_q & out_ready;

  always_comb begin
    rdy_d  = 1'b1;
    mv_d   = mv_q;
    sv_d   = sv_q;
    main_d = main_q;
    skid_d = skid_q;
    if (deq) begin
      if (sv_q) begin
        main_d = skid_q;
        sv_d   = 1'b0;
      end else if (acc) begin
        main_d = new_e;
      end else begin
        mv_d = 1'b0;
      end
    end else if (acc) begin
      if (!mv_q) begin
        main_d = new_e;
        mv_d   = 1'b1;
      end else begin
        skid_d = new_e;
        sv_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdy_q  <= 1'b0;
      mv_q   <= 1'b0;
      sv_q   <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      rdy_q  <= rdy_d;
      mv_q   <= mv_d;
      sv_q   <= sv_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign out_valid   = mv_q;
  assign out_imm     = main_q.imm;
  assign out_tag     = main_q.tag;
  assign out_illegal = main_q.illegal;

endmodule
